// File: rtl/alu_req_responder.sv
// ALU request responder: 8-op signed ALU feeding a response FIFO.
// Build option ALU_SATURATE_EN clamps overflowing arithmetic results.
module alu_req_responder #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             err,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH:0]   xa;
  logic [WIDTH:0]   xb;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] val;
  logic             ovf;

  always_comb begin
    xa  = {a[WIDTH-1], a};
    xb  = {b[WIDTH-1], b};
    sum = '0;
    unique case (op)
      3'd0: sum = xa + xb;
      3'd1: sum = xa - xb;
      3'd2: sum = xa - ONE;
      3'd3: sum = xa + ONE;
      3'd4: sum = {1'b0, ~a};
      3'd5: sum = {1'b0, a & b};
      3'd6: sum = {1'b0, a | b};
      3'd7: sum = {1'b0, a ^ b};
      default: sum = '0;
    endcase
    // the extra top bit is the true sign; disagreement means overflow
    ovf = !op[2] && (sum[WIDTH] != sum[WIDTH-1]);
`ifdef ALU_SATURATE_EN
    if (ovf)
      val = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                       : {1'b0, {(WIDTH-1){1'b1}}};
    else
      val = sum[WIDTH-1:0];
`else
    val = sum[WIDTH-1:0];
`endif
  end

  logic [WIDTH:0]  mem [DEPTH];
  logic [AW-1:0]   rptr;
  logic [AW-1:0]   wptr;
  logic [AW:0]     cnt;
  logic [AW:0]     cnt_nxt;
  logic            push;
  logic            pop;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)
      cnt_nxt = cnt + (AW+1)'(1);
    else if (!push && pop)
      cnt_nxt = cnt - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr      <= '0;
      wptr      <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ovf_cnt   <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= {ovf, val};
        wptr      <= wptr + AW'(1);
      end
      if (pop)
        rptr <= rptr + AW'(1);
      cnt       <= cnt_nxt;
      in_ready  <= (cnt_nxt != FULL);
      out_valid <= (cnt_nxt != '0);
      if (push && ovf && (ovf_cnt != '1))
        ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

  assign {err, res} = mem[rptr];

endmodule
